uart_tx: RTL and testbench

Serial UART transmitter that converts a parallel byte into an asynchronous frame on a single line. The frame is start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits. It sits between a byte-producing client (CPU/bus bridge) and the chip's TX pin. The client requests with a level-sensitive enable, and the block reports occupancy with a busy flag.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx.sv | 102 ++++++++++
 tb/tb_uart_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings and the data width.
// The parity helper is shared so a future RX can compute the same bit.
package uart_pkg;

    localparam int DATA_W   = 8;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input int mode);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and pulses bit_tick for one cycle at terminal count.
// Held at zero while clr is high so each frame starts on a clean bit boundary.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = !clr && (cnt == TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr || bit_tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Level-sensitive trans_en; inputs are sampled only at the launch edge in IDLE.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] trans_data,
    input  logic              trans_en,
    output logic              trans_busy,
    output logic              txd
);

    generate
        if (CLKS_PER_BIT < 2 || PARITY < PAR_NONE || PARITY > PAR_ODD ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
            $error("uart_tx: illegal parameter value");
        end
    endgenerate

    uart_state_e       state;
    logic [DATA_W-1:0] shift_reg;
    logic [2:0]        bit_cnt;
    logic              stop_cnt;
    logic              par_bit;
    logic              bit_tick;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_IDLE),
        .bit_tick (bit_tick)
    );

    assign trans_busy = (state != ST_IDLE);

    // txd is loaded with the next bit on the same edge that changes state,
    // so the line never lags the FSM by a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
            txd       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    txd      <= 1'b1;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    if (trans_en) begin
                        shift_reg <= trans_data;
                        par_bit   <= parity_bit(trans_data, PARITY);
                        txd       <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: if (bit_tick) begin
                    txd   <= shift_reg[0];
                    state <= ST_DATA;
                end
                ST_DATA: if (bit_tick) begin
                    if (bit_cnt == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            txd   <= par_bit;
                            state <= ST_PARITY;
                        end else begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end
                    end else begin
                        bit_cnt   <= bit_cnt + 3'd1;
                        shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
                        txd       <= shift_reg[1];
                    end
                end
                ST_PARITY: if (bit_tick) begin
                    txd   <= 1'b1;
                    state <= ST_STOP;
                end
                ST_STOP: if (bit_tick) begin
                    txd <= 1'b1;
                    if (stop_cnt == 1'(STOP_BITS - 1))
                        state <= ST_IDLE;
                    else
                        stop_cnt <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: three instances cover
// no-parity/1-stop, even/2-stop and odd/2-stop on shared stimulus.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] trans_data;
    logic       trans_en;
    logic [2:0] txd_w;
    logic [2:0] busy_w;

    int total = 0;
    int bad   = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .trans_data(trans_data), .trans_en(trans_en),
        .trans_busy(busy_w[0]), .txd(txd_w[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .trans_data(trans_data), .trans_en(trans_en),
        .trans_busy(busy_w[1]), .txd(txd_w[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .trans_data(trans_data), .trans_en(trans_en),
        .trans_busy(busy_w[2]), .txd(txd_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a launch edge; bits holds one char per serial bit.
    task automatic check_frame(input string name, input int w, input string bits);
        int   n;
        logic exp;
        n = bits.len() * CPB;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp = (bits[i / CPB] == "1");
            total++;
            if (txd_w[w] !== exp) begin
                bad++;
                $display("FAIL %s txd cyc=%0d got=%b want=%b", name, i, txd_w[w], exp);
            end
            total++;
            if (busy_w[w] !== 1'b1) begin
                bad++;
                $display("FAIL %s busy cyc=%0d got=%b want=1", name, i, busy_w[w]);
            end
        end
        @(negedge clk);
        total++;
        if (busy_w[w] !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_end got=%b want=0", name, busy_w[w]);
        end
        total++;
        if (txd_w[w] !== 1'b1) begin
            bad++;
            $display("FAIL %s txd_end got=%b want=1", name, txd_w[w]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        trans_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic launch(input logic [7:0] d, input bit hold);
        @(negedge clk);
        trans_data = d;
        trans_en = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) trans_en = 1'b0;
    endtask

    task automatic test_reset();
        #8;
        for (int w = 0; w < 3; w++) begin
            total++;
            if (txd_w[w] !== 1'b1) begin
                bad++;
                $display("FAIL reset_txd dut%0d got=%b want=1", w, txd_w[w]);
            end
            total++;
            if (busy_w[w] !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy dut%0d got=%b want=0", w, busy_w[w]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            for (int w = 0; w < 3; w++) begin
                total++;
                if (txd_w[w] !== 1'b1 || busy_w[w] !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_hold dut%0d txd=%b busy=%b want 1/0", w, txd_w[w], busy_w[w]);
                end
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        launch(8'h12, 1'b0);
        check_frame("single_12", 0, "0010010001");
    endtask

    task automatic test_back_to_back();
        do_reset();
        launch(8'h34, 1'b1);
        trans_data = 8'h87;
        check_frame("b2b_first", 0, "0001011001");
        check_frame("b2b_second", 0, "0111000011");
        trans_en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stop busy got=%b want=0", busy_w[0]);
        end
    endtask

    task automatic test_parity();
        do_reset();
        launch(8'h12, 1'b0);
        check_frame("par_even", 1, "001001000011");
        do_reset();
        launch(8'h12, 1'b0);
        check_frame("par_odd", 2, "001001000111");
    endtask

    task automatic test_mid_reset();
        do_reset();
        launch(8'h12, 1'b0);
        repeat (18) @(negedge clk);
        total++;
        if (txd_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre txd=%b busy=%b want 0/1", txd_w[0], busy_w[0]);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (txd_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_async_txd got=%b want=1", txd_w[0]);
        end
        total++;
        if (busy_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_busy got=%b want=0", busy_w[0]);
        end
        @(negedge clk);
        trans_data = 8'h12;
        trans_en = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 trans_en = 1'b0;
        check_frame("mid_restart", 0, "0010010001");
    endtask

    task automatic test_stability();
        do_reset();
        launch(8'h12, 1'b0);
        fork
            check_frame("stable", 0, "0010010001");
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1 trans_data = 8'($urandom);
                end
            end
        join
    endtask

    initial begin
        rst = 1'b0;
        trans_en = 1'b0;
        trans_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_mid_reset();
        test_stability();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
